// File: rtl/screen_select_ctrl_pkg.sv
// Shared definitions for the screen select controller.
// Holds the state encoding so the top-level logic and anything decoding
// state_out (debug LEDs, testbenches) agree on the codes.
//   StTitle = 0, StArm = 1, StGame = 2, StHold = 3
package screen_select_ctrl_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StTitle = 2'd0,
    StArm   = 2'd1,
    StGame  = 2'd2,
    StHold  = 2'd3
  } state_e;

  // Outputs for a screen source choice; title and game selects are one-hot.
  function automatic logic [1:0] sel_for_title(input logic title);
    return title ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector.
// Registers the input level and produces a one-cycle pulse in the cycle the
// level is first seen high. The history register resets to 0, so an input
// already high when reset releases produces a pulse in the first cycle.
// Ports:
//   pclk  - clock
//   rst   - asynchronous active-high reset
//   in    - level input, synchronous to pclk
//   pulse - in & ~in_q
module rise_edge_det (
  input  logic pclk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic in_q;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/screen_select_ctrl.sv
// Game-flow controller for the screen multiplexer.
// Sequences TITLE -> ARM -> GAME -> HOLD -> TITLE. The screen source only
// changes on a rising edge of vertical blanking so no frame tears, and the
// game-logic reset pulse is aligned with that frame boundary.
// Ports:
//   pclk       - pixel clock
//   rst        - asynchronous active-high reset
//   vblnk_in   - vertical blank level
//   start_btn  - debounced start button level
//   game_over  - high when the player has lost
//   title_sel  - selects title screen (one-hot with game_sel)
//   game_sel   - selects game screen
//   game_rst   - one-cycle pulse clearing game state on ARM -> GAME
//   game_run   - high while gameplay is live
//   state_out  - current state code
module screen_select_ctrl
  import screen_select_ctrl_pkg::*;
#(
  parameter int unsigned OVER_HOLD_FRAMES = 180,
  parameter int unsigned FRAME_CNT_W      = 8
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vblnk_in,
  input  logic              start_btn,
  input  logic              game_over,
  output logic              title_sel,
  output logic              game_sel,
  output logic              game_rst,
  output logic              game_run,
  output logic [StateW-1:0] state_out
);

  localparam logic [FRAME_CNT_W-1:0] HoldLast = FRAME_CNT_W'(OVER_HOLD_FRAMES - 1);

  logic start_rise;
  logic vb_rise;

  rise_edge_det u_start_edge (
    .pclk  (pclk),
    .rst   (rst),
    .in    (start_btn),
    .pulse (start_rise)
  );

  rise_edge_det u_vblnk_edge (
    .pclk  (pclk),
    .rst   (rst),
    .in    (vblnk_in),
    .pulse (vb_rise)
  );

  state_e                 state_q, state_d;
  logic                   title_sel_q, title_sel_d;
  logic                   game_sel_q, game_sel_d;
  logic                   game_rst_q, game_rst_d;
  logic                   game_run_q, game_run_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    title_sel_d = title_sel_q;
    game_sel_d  = game_sel_q;
    game_rst_d  = 1'b0;
    game_run_d  = game_run_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      StTitle: begin
        // A vblank edge in the same cycle is deliberately not acted on here;
        // ARM waits for the next frame boundary.
        if (start_rise) begin
          state_d = StArm;
        end
      end
      StArm: begin
        if (vb_rise) begin
          state_d                  = StGame;
          {game_sel_d, title_sel_d} = sel_for_title(1'b0);
          game_rst_d               = 1'b1;
          game_run_d               = 1'b1;
        end
      end
      StGame: begin
        // game_over may still be stale from the previous game while the
        // clearing pulse is out; only trust it once game_rst has dropped.
        if (game_over && !game_rst_q) begin
          state_d    = StHold;
          game_run_d = 1'b0;
          cnt_d      = '0;
        end
      end
      StHold: begin
        if (vb_rise) begin
          if (cnt_q == HoldLast) begin
            state_d                   = StTitle;
            {game_sel_d, title_sel_d} = sel_for_title(1'b1);
            cnt_d                     = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StTitle;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= StTitle;
      title_sel_q <= 1'b1;
      game_sel_q  <= 1'b0;
      game_rst_q  <= 1'b0;
      game_run_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      title_sel_q <= title_sel_d;
      game_sel_q  <= game_sel_d;
      game_rst_q  <= game_rst_d;
      game_run_q  <= game_run_d;
      cnt_q       <= cnt_d;
    end
  end

  assign title_sel = title_sel_q;
  assign game_sel  = game_sel_q;
  assign game_rst  = game_rst_q;
  assign game_run  = game_run_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_screen_select_ctrl.sv
// Testbench for screen_select_ctrl: two instances (hold of 3 frames and of
// 1 frame) share stimulus and are compared every cycle against a
// phase-based reference model.
module tb_screen_select_ctrl;

  logic pclk = 1'b0;
  logic rst;
  logic vblnk_in;
  logic start_btn;
  logic game_over;

  logic       title_sel [2];
  logic       game_sel  [2];
  logic       game_rst  [2];
  logic       game_run  [2];
  logic [1:0] state_out [2];

  always #5 pclk = ~pclk;

  screen_select_ctrl #(
    .OVER_HOLD_FRAMES (3),
    .FRAME_CNT_W      (8)
  ) u_dut3 (
    .pclk      (pclk),
    .rst       (rst),
    .vblnk_in  (vblnk_in),
    .start_btn (start_btn),
    .game_over (game_over),
    .title_sel (title_sel[0]),
    .game_sel  (game_sel[0]),
    .game_rst  (game_rst[0]),
    .game_run  (game_run[0]),
    .state_out (state_out[0])
  );

  screen_select_ctrl #(
    .OVER_HOLD_FRAMES (1),
    .FRAME_CNT_W      (4)
  ) u_dut1 (
    .pclk      (pclk),
    .rst       (rst),
    .vblnk_in  (vblnk_in),
    .start_btn (start_btn),
    .game_over (game_over),
    .title_sel (title_sel[1]),
    .game_sel  (game_sel[1]),
    .game_rst  (game_rst[1]),
    .game_run  (game_run[1]),
    .state_out (state_out[1])
  );

  // Reference model: phase 0 title, 1 armed, 2 playing, 3 frozen game-over.
  int lim    [2] = '{3, 1};
  int phase  [2];
  int frames [2];
  bit fresh  [2];  // true during the first cycle of play (reset pulse out)
  bit prev_s [2];
  bit prev_v [2];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      phase[i]  = 0;
      frames[i] = 0;
      fresh[i]  = 1'b0;
      prev_s[i] = 1'b0;
      prev_v[i] = 1'b0;
    end
  endtask

  task automatic model_clock();
    for (int i = 0; i < 2; i++) begin
      bit sr, vr, nf;
      if (rst) begin
        phase[i]  = 0;
        frames[i] = 0;
        fresh[i]  = 1'b0;
        prev_s[i] = 1'b0;
        prev_v[i] = 1'b0;
      end else begin
        sr = start_btn && !prev_s[i];
        vr = vblnk_in && !prev_v[i];
        prev_s[i] = start_btn;
        prev_v[i] = vblnk_in;
        nf = 1'b0;
        case (phase[i])
          0: if (sr) phase[i] = 1;
          1: if (vr) begin
            phase[i] = 2;
            nf = 1'b1;
          end
          2: if (game_over && !fresh[i]) begin
            phase[i]  = 3;
            frames[i] = 0;
          end
          default: if (vr) begin
            frames[i] = frames[i] + 1;
            if (frames[i] >= lim[i]) phase[i] = 0;
          end
        endcase
        fresh[i] = nf;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("state_out[%0d]", i), state_out[i], 2'(phase[i]));
      chk($sformatf("title_sel[%0d]", i), {1'b0, title_sel[i]}, {1'b0, phase[i] < 2});
      chk($sformatf("game_sel[%0d]", i), {1'b0, game_sel[i]}, {1'b0, phase[i] >= 2});
      chk($sformatf("game_run[%0d]", i), {1'b0, game_run[i]}, {1'b0, phase[i] == 2});
      chk($sformatf("game_rst[%0d]", i), {1'b0, game_rst[i]}, {1'b0, fresh[i]});
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic v, input logic g);
    @(negedge pclk);
    rst       = r;
    start_btn = s;
    vblnk_in  = v;
    game_over = g;
    @(posedge pclk);
    model_clock();
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic vb_pulse();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(6);
  endtask

  initial begin
    rst       = 1'b1;
    vblnk_in  = 1'b0;
    start_btn = 1'b0;
    game_over = 1'b0;
    model_reset();
    #2 check_all();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Start request: 5-cycle press, vblank 100 cycles later.
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(100);
    vb_pulse();

    // Start press during play is ignored; then game over and the hold.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);  // ignored in hold
    idle(2);
    vb_pulse();  // 1-frame instance returns to title here
    vb_pulse();
    vb_pulse();  // 3-frame instance returns to title here
    idle(4);

    // Start and vblank rise together in title: arm only, switch next frame.
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    idle(5);
    // game_over pulse while armed is ignored.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    vb_pulse();

    // Asynchronous reset in the middle of play.
    @(negedge pclk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    // vblank held high across reset release.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Randomized traffic with periodic vblank and occasional resets.
    for (int k = 0; k < 4000; k++) begin
      logic r, s, v, g;
      r = ($urandom_range(0, 599) == 0);
      s = ($urandom_range(0, 29) == 0) ? ~start_btn : start_btn;
      v = ((k % 23) < 3) ^ ($urandom_range(0, 49) == 0);
      g = ($urandom_range(0, 19) == 0);
      cyc(r, s, v, g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
